// File: rtl/cga_io_initiator.sv
// ============================================================================
// Module   : cga_io_initiator
// Brief    : ISA I/O initiator that programs CGA CRTC/mode/colour registers
//            from an internal mode table, optionally waiting for vertical retrace.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cga_io_initiator #(
    parameter logic [15:0] IO_BASE_ADDR  = 16'h3d0,
    parameter int          SETUP_CYCLES  = 2,
    parameter int          STROBE_CYCLES = 4,
    parameter int          HOLD_CYCLES   = 2,
    parameter bit          WAIT_VSYNC    = 1'b1,
    parameter bit          VSYNC_BIT_POL = 1'b1,
    parameter logic [15:0] POLL_TIMEOUT  = 16'd4096
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        start,
    input  logic [1:0]  mode_sel,
    output logic [14:0] bus_a,
    output logic [7:0]  bus_d,
    input  logic [7:0]  bus_in,
    output logic        bus_iow_l,
    output logic        bus_ior_l,
    output logic        bus_aen,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POLL  = 3'd1,
        S_BLANK = 3'd2,
        S_CRTC  = 3'd3,
        S_COLOR = 3'd4,
        S_MODE  = 3'd5,
        S_DONE  = 3'd6
    } seq_t;

    typedef enum logic [1:0] {
        P_ADDR   = 2'd0,
        P_STROBE = 2'd1,
        P_HOLD   = 2'd2
    } phase_t;

    localparam logic [14:0] c_addr_index  = 15'(IO_BASE_ADDR + 16'h4);
    localparam logic [14:0] c_addr_data   = 15'(IO_BASE_ADDR + 16'h5);
    localparam logic [14:0] c_addr_mode   = 15'(IO_BASE_ADDR + 16'h8);
    localparam logic [14:0] c_addr_colour = 15'(IO_BASE_ADDR + 16'h9);
    localparam logic [14:0] c_addr_status = 15'(IO_BASE_ADDR + 16'ha);
    localparam logic [3:0]  c_setup_last  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0]  c_strobe_last = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0]  c_hold_last   = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0]  c_crtc_last   = 4'd11;

    seq_t        r_seq, w_seq_nxt;
    phase_t      r_phase, w_phase_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [1:0]  r_mode, w_mode_nxt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic        r_data_ph, w_data_ph_nxt;
    logic [15:0] r_poll_cnt, w_poll_cnt_nxt;
    logic        r_match, w_match_nxt;
    logic        r_timeout, w_timeout_nxt;
    logic        w_cycle_end;
    logic [15:0] w_poll_inc;
    logic        w_bus_active;
    logic [14:0] w_addr;
    logic [7:0]  w_data;
    logic        w_unused_bus_in;

    // Only the retrace bit of the status register matters here.
    assign w_unused_bus_in = ^{bus_in[7:4], bus_in[2:0]};

    // CRTC table: 80-column text differs in R0..R2, graphics modes in R4/R6/R7/R9.
    function automatic logic [7:0] f_crtc(input logic [1:0] m, input logic [3:0] i);
        logic text80;
        logic gfx;
        text80 = (m == 2'd0);
        gfx    = m[1];
        case (i)
            4'd0:    f_crtc = text80 ? 8'h71 : 8'h38;
            4'd1:    f_crtc = text80 ? 8'h50 : 8'h28;
            4'd2:    f_crtc = text80 ? 8'h5a : 8'h2d;
            4'd3:    f_crtc = 8'h0a;
            4'd4:    f_crtc = gfx ? 8'h7f : 8'h1f;
            4'd5:    f_crtc = 8'h06;
            4'd6:    f_crtc = gfx ? 8'h64 : 8'h19;
            4'd7:    f_crtc = gfx ? 8'h70 : 8'h1c;
            4'd8:    f_crtc = 8'h02;
            4'd9:    f_crtc = gfx ? 8'h01 : 8'h07;
            4'd10:   f_crtc = 8'h06;
            default: f_crtc = 8'h07;
        endcase
    endfunction

    function automatic logic [7:0] f_mode(input logic [1:0] m);
        case (m)
            2'd0:    f_mode = 8'h29;
            2'd1:    f_mode = 8'h28;
            2'd2:    f_mode = 8'h2a;
            default: f_mode = 8'h1e;
        endcase
    endfunction

    function automatic logic [7:0] f_colour(input logic [1:0] m);
        f_colour = (m == 2'd3) ? 8'h3f : 8'h30;
    endfunction

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_seq      <= S_IDLE;
            r_phase    <= P_ADDR;
            r_cnt      <= 4'd0;
            r_mode     <= 2'd0;
            r_idx      <= 4'd0;
            r_data_ph  <= 1'b0;
            r_poll_cnt <= 16'd0;
            r_match    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_seq      <= w_seq_nxt;
            r_phase    <= w_phase_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mode     <= w_mode_nxt;
            r_idx      <= w_idx_nxt;
            r_data_ph  <= w_data_ph_nxt;
            r_poll_cnt <= w_poll_cnt_nxt;
            r_match    <= w_match_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign w_poll_inc = (r_poll_cnt == 16'hffff) ? r_poll_cnt : r_poll_cnt + 16'd1;

    always_comb begin
        w_seq_nxt      = r_seq;
        w_phase_nxt    = r_phase;
        w_cnt_nxt      = r_cnt;
        w_mode_nxt     = r_mode;
        w_idx_nxt      = r_idx;
        w_data_ph_nxt  = r_data_ph;
        w_poll_cnt_nxt = r_poll_cnt;
        w_match_nxt    = r_match;
        w_timeout_nxt  = r_timeout;
        w_cycle_end    = 1'b0;

        case (r_seq)
            S_IDLE: begin
                if (start) begin
                    w_seq_nxt      = WAIT_VSYNC ? S_POLL : S_BLANK;
                    w_phase_nxt    = P_ADDR;
                    w_cnt_nxt      = 4'd0;
                    w_mode_nxt     = mode_sel;
                    w_idx_nxt      = 4'd0;
                    w_data_ph_nxt  = 1'b0;
                    w_poll_cnt_nxt = 16'd0;
                    w_match_nxt    = 1'b0;
                    w_timeout_nxt  = 1'b0;
                end
            end
            S_DONE: w_seq_nxt = S_IDLE;
            default: begin
                case (r_phase)
                    P_ADDR: begin
                        if (r_cnt == c_setup_last) begin
                            w_phase_nxt = P_STROBE;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end
                    P_STROBE: begin
                        if (r_cnt == c_strobe_last) begin
                            w_phase_nxt = P_HOLD;
                            w_cnt_nxt   = 4'd0;
                            if (r_seq == S_POLL) begin
                                w_match_nxt = (bus_in[3] == VSYNC_BIT_POL);
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end
                    default: begin
                        if (r_cnt == c_hold_last) begin
                            w_phase_nxt = P_ADDR;
                            w_cnt_nxt   = 4'd0;
                            w_cycle_end = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end
                endcase

                if (w_cycle_end) begin
                    case (r_seq)
                        S_POLL: begin
                            w_poll_cnt_nxt = w_poll_inc;
                            if (r_match) begin
                                w_seq_nxt = S_BLANK;
                            end else if (w_poll_inc >= POLL_TIMEOUT) begin
                                w_seq_nxt     = S_BLANK;
                                w_timeout_nxt = 1'b1;
                            end
                        end
                        S_BLANK: w_seq_nxt = S_CRTC;
                        S_CRTC: begin
                            if (r_data_ph) begin
                                w_data_ph_nxt = 1'b0;
                                if (r_idx == c_crtc_last) begin
                                    w_seq_nxt = S_COLOR;
                                end else begin
                                    w_idx_nxt = r_idx + 4'd1;
                                end
                            end else begin
                                w_data_ph_nxt = 1'b1;
                            end
                        end
                        S_COLOR: w_seq_nxt = S_MODE;
                        default: w_seq_nxt = S_DONE;
                    endcase
                end
            end
        endcase
    end

    assign w_bus_active = (r_seq != S_IDLE) && (r_seq != S_DONE);

    always_comb begin
        w_addr = 15'd0;
        w_data = 8'd0;
        case (r_seq)
            S_POLL:  w_addr = c_addr_status;
            S_BLANK: begin
                w_addr = c_addr_mode;
                w_data = f_mode(r_mode) & 8'hf7;
            end
            S_CRTC: begin
                w_addr = r_data_ph ? c_addr_data : c_addr_index;
                w_data = r_data_ph ? f_crtc(r_mode, r_idx) : {4'd0, r_idx};
            end
            S_COLOR: begin
                w_addr = c_addr_colour;
                w_data = f_colour(r_mode);
            end
            S_MODE: begin
                w_addr = c_addr_mode;
                w_data = f_mode(r_mode);
            end
            default: begin
                w_addr = 15'd0;
                w_data = 8'd0;
            end
        endcase
    end

    assign bus_a     = w_addr;
    assign bus_d     = w_data;
    assign bus_aen   = ~w_bus_active;
    assign bus_iow_l = ~(w_bus_active && (r_phase == P_STROBE) && (r_seq != S_POLL));
    assign bus_ior_l = ~(w_bus_active && (r_phase == P_STROBE) && (r_seq == S_POLL));
    assign busy      = w_bus_active;
    assign done      = (r_seq == S_DONE);
    assign timeout   = r_timeout;

endmodule

`default_nettype wire
